// File: rtl/issue_queue_if.sv
// issue_queue_if: handshake and data bundle between fetch/ID and the issue queue.
// master = fetch/ID side (drives pushes and control), slave = the issue queue.
// The dual_cnt_o/stall_cnt_o counters are always present; they are only
// live when the queue is built with ISSUE_PERF_EN.
interface issue_queue_if #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 152
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               flush_i;
    logic               id_allowin_i;
    logic               dual_en_i;
    logic [1:0]         push_num_i;
    logic [ENTRY_W-1:0] push_bus0_i;
    logic [ENTRY_W-1:0] push_bus1_i;
    logic               push_ready_o;
    logic [CNT_W-1:0]   count_o;
    logic [1:0]         issue_mode_o;
    logic [ENTRY_W-1:0] issue_bus0_o;
    logic [ENTRY_W-1:0] issue_bus1_o;
    logic [31:0]        dual_cnt_o;
    logic [31:0]        stall_cnt_o;

    modport master (
        output flush_i, id_allowin_i, dual_en_i, push_num_i, push_bus0_i, push_bus1_i,
        input  push_ready_o, count_o, issue_mode_o, issue_bus0_o, issue_bus1_o,
               dual_cnt_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, id_allowin_i, dual_en_i, push_num_i, push_bus0_i, push_bus1_i,
        output push_ready_o, count_o, issue_mode_o, issue_bus0_o, issue_bus1_o,
               dual_cnt_o, stall_cnt_o
    );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: circular instruction FIFO between fetch and ID with an in-order
// dual-issue selector (register/HILO hazards, single-issue classes, delay-slot hold).
// Optional macro ISSUE_PERF_EN enables the dual-issue and stall performance counters;
// without it both counter outputs are tied to zero and no counter flops exist.
module issue_queue #(
    parameter int INST_W  = 128,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = INST_W + 24
) (
    input  logic        clk,
    input  logic        rst,   // asynchronous, active-low
    issue_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        NO_ISSUE     = 2'b00,
        SINGLE_ISSUE = 2'b01,
        DOUBLE_ISSUE = 2'b10
    } issue_mode_e;

    // Entry metadata, bits [23:0]; first field is the MSB.
    typedef struct packed {
        logic       rsvd;
        logic       wait_delayslot;
        logic       only_issue;
        logic       not_2_issue;
        logic       hilo_read;
        logic       hilo_write;
        logic [4:0] r2_addr;
        logic       r2_read;
        logic [4:0] r1_addr;
        logic       r1_read;
        logic [4:0] waddr;
        logic       reg_write;
    } meta_t;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [PTR_W-1:0]   w_rd_ptr_p1;
    logic [PTR_W-1:0]   w_wr_ptr_p1;
    logic [ENTRY_W-1:0] w_head0;
    logic [ENTRY_W-1:0] w_head1;
    meta_t              w_p;
    meta_t              w_s;
    logic               w_push_ready;
    logic [1:0]         w_push_n;
    logic               w_reg_hz;
    logic               w_hilo_hz;
    logic               w_need_single;
    issue_mode_e        w_mode;
    logic [1:0]         w_issued;

    // Pointers are exactly PTR_W bits wide, so +1 wraps modulo DEPTH for free.
    assign w_rd_ptr_p1 = r_rd_ptr + 1'b1;
    assign w_wr_ptr_p1 = r_wr_ptr + 1'b1;

    assign w_head0 = r_mem[r_rd_ptr];
    assign w_head1 = r_mem[w_rd_ptr_p1];
    assign w_p     = meta_t'(w_head0[23:0]);
    assign w_s     = meta_t'(w_head1[23:0]);

    // Room for a full two-entry push is required before any push is taken.
    assign w_push_ready = (r_count <= CNT_W'(DEPTH - 2));

    // Accepted push count: 3 is illegal, a not-ready or flushed push is dropped whole.
    assign w_push_n = (q.flush_i || !w_push_ready || q.push_num_i == 2'd3)
                      ? 2'd0 : q.push_num_i;

    assign w_reg_hz = w_p.reg_write && (w_p.waddr != 5'd0) &&
                      ((w_s.r1_read && (w_p.waddr == w_s.r1_addr)) ||
                       (w_s.r2_read && (w_p.waddr == w_s.r2_addr)));
    assign w_hilo_hz = w_p.hilo_write && w_s.hilo_read;
    assign w_need_single = w_s.not_2_issue || w_s.only_issue || w_p.only_issue ||
                           w_reg_hz || w_hilo_hz || !q.dual_en_i;

    // Issue-mode selection in priority order: blockers, single-issue reasons, dual.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_mode   = NO_ISSUE;
        w_issued = 2'd0;
        if (r_count == CNT_W'(0) || q.flush_i || !q.id_allowin_i ||
            (r_count == CNT_W'(1) && w_p.wait_delayslot)) begin
            w_mode   = NO_ISSUE;
            w_issued = 2'd0;
        end else if (r_count == CNT_W'(1) || w_need_single) begin
            w_mode   = SINGLE_ISSUE;
            w_issued = 2'd1;
        end else begin
            w_mode   = DOUBLE_ISSUE;
            w_issued = 2'd2;
        end
    end

    // Pointer and occupancy update; flush empties the queue and drops this cycle's pushes.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (q.flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_issued);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
            r_count  <= r_count + CNT_W'(w_push_n) - CNT_W'(w_issued);
        end
    end

    // Entry storage writes for accepted pushes, older entry at wr_ptr.
    always_ff @(posedge clk) begin
        // NOTE: the entry array has no reset; validity is tracked by count, so stale data is harmless.
        if (w_push_n != 2'd0) begin
            r_mem[r_wr_ptr] <= q.push_bus0_i;
        end
        if (w_push_n == 2'd2) begin
            r_mem[w_wr_ptr_p1] <= q.push_bus1_i;
        end
    end

    assign q.push_ready_o = w_push_ready;
    assign q.count_o      = r_count;
    assign q.issue_mode_o = w_mode;
    assign q.issue_bus0_o = w_head0;
    assign q.issue_bus1_o = w_head1;

`ifdef ISSUE_PERF_EN
    logic [31:0] r_dual_cnt;
    logic [31:0] r_stall_cnt;

    // Performance counters: dual-issue cycles and cycles ID waited on a non-empty queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dual_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_mode == DOUBLE_ISSUE) begin
                r_dual_cnt <= r_dual_cnt + 32'd1;
            end
            if (r_count != CNT_W'(0) && q.id_allowin_i && !q.flush_i && w_mode == NO_ISSUE) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign q.dual_cnt_o  = r_dual_cnt;
    assign q.stall_cnt_o = r_stall_cnt;
`else
    assign q.dual_cnt_o  = 32'h0;
    assign q.stall_cnt_o = 32'h0;
`endif

    // Several metadata fields only matter on one of the two slots; sink the rest.
    logic w_unused;
    assign w_unused = ^{w_p, w_s};

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue with
// hand-computed expectations (dual issue, hazards, delay-slot hold,
// full/wrap, flush, asynchronous reset, performance counters).
module tb_issue_queue;
    localparam int DEPTH  = 8;
    localparam int INST_W = 128;
    localparam int EW     = INST_W + 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    issue_queue_if #(.DEPTH(DEPTH), .ENTRY_W(EW)) bus ();

    issue_queue #(.INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] md(input logic wr, input logic [4:0] wa,
                                       input logic r1, input logic [4:0] r1a,
                                       input logic r2, input logic [4:0] r2a,
                                       input logic hw, input logic hr,
                                       input logic n2, input logic only, input logic wds);
        return {1'b0, wds, only, n2, hr, hw, r2a, r2, r1a, r1, wa, wr};
    endfunction

    function automatic logic [EW-1:0] mk(input logic [23:0] meta, input logic [INST_W-1:0] pay);
        return {pay, meta};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] n, input logic [EW-1:0] b0, input logic [EW-1:0] b1);
        bus.push_num_i  = n;
        bus.push_bus0_i = b0;
        bus.push_bus1_i = b1;
    endtask

    logic [EW-1:0] alu_a, alu_b, hz_p, hz_s, br, ds, junk;
    logic [EW-1:0] e [9];

    initial begin
        alu_a = mk(md(1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0), 128'hA0);
        alu_b = mk(md(1, 5'd4, 1, 5'd6, 1, 5'd7, 0, 0, 0, 0, 0), 128'hB0);
        hz_p  = mk(md(1, 5'd5, 1, 5'd8, 1, 5'd9, 0, 0, 0, 0, 0), 128'hC0);
        hz_s  = mk(md(1, 5'd10, 1, 5'd11, 1, 5'd5, 0, 0, 0, 0, 0), 128'hC1);
        br    = mk(md(0, 5'd0, 1, 5'd4, 1, 5'd6, 0, 0, 1, 0, 1), 128'hB1);
        ds    = mk(md(1, 5'd12, 1, 5'd13, 0, 5'd0, 0, 0, 1, 0, 0), 128'hD5);
        junk  = mk(md(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0), 128'hDEAD);
        for (int i = 0; i < 9; i++) begin
            e[i] = mk(md(1, 5'(16 + i), 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0), 128'(32'hE00 + i));
        end

        bus.flush_i      = 1'b0;
        bus.id_allowin_i = 1'b1;
        bus.dual_en_i    = 1'b1;
        drive(2'd0, '0, '0);

        // Reset state
        #1;
        check("rst_count", bus.count_o, 0);
        check("rst_ready", bus.push_ready_o, 1);
        check("rst_mode", bus.issue_mode_o, 2'b00);
        check("rst_dual_cnt", bus.dual_cnt_o, 0);
        check("rst_stall_cnt", bus.stall_cnt_o, 0);
        #2 rst = 1'b1;

        // Two independent ALU ops dual-issue the cycle after the push
        drive(2'd2, alu_a, alu_b);
        #1 check("t1_mode_empty", bus.issue_mode_o, 2'b00);
        tick;
        drive(2'd0, '0, '0);
        #1;
        check("t1_count2", bus.count_o, 2);
        check("t1_mode_dual", bus.issue_mode_o, 2'b10);
        check("t1_bus0", bus.issue_bus0_o, alu_a);
        check("t1_bus1", bus.issue_bus1_o, alu_b);
        tick;
        check("t1_count0", bus.count_o, 0);

        // RAW hazard through r2 forces single issue
        drive(2'd2, hz_p, hz_s);
        #1 check("t2_mode_empty", bus.issue_mode_o, 2'b00);
        tick;
        drive(2'd0, '0, '0);
        #1;
        check("t2_mode_single", bus.issue_mode_o, 2'b01);
        check("t2_bus0", bus.issue_bus0_o, hz_p);
        tick;
        check("t2_count1", bus.count_o, 1);
        check("t2_mode_single2", bus.issue_mode_o, 2'b01);
        check("t2_bus0_sec", bus.issue_bus0_o, hz_s);
        tick;
        check("t2_count0", bus.count_o, 0);

        // Lone branch waits for its delay slot
        drive(2'd1, br, '0);
        tick;
        drive(2'd0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_hold_mode", bus.issue_mode_o, 2'b00);
            check("t3_hold_count", bus.count_o, 1);
            tick;
        end
        drive(2'd1, ds, '0);
        #1 check("t3_push_ds_mode", bus.issue_mode_o, 2'b00);
        tick;
        drive(2'd0, '0, '0);
        #1;
        check("t3_br_mode", bus.issue_mode_o, 2'b01);
        check("t3_br_bus0", bus.issue_bus0_o, br);
        tick;
        check("t3_ds_mode", bus.issue_mode_o, 2'b01);
        check("t3_ds_bus0", bus.issue_bus0_o, ds);
        tick;
        check("t3_count0", bus.count_o, 0);

        // Fill to DEPTH-1 with ID blocked; pointers start at 6 so this wraps
        bus.id_allowin_i = 1'b0;
        drive(2'd2, e[0], e[1]); tick;
        drive(2'd2, e[2], e[3]); tick;
        drive(2'd2, e[4], e[5]);
        tick;
        check("t4_count6", bus.count_o, 6);
        check("t4_ready6", bus.push_ready_o, 1);
        drive(2'd1, e[6], '0);
        tick;
        drive(2'd2, junk, junk);
        #1;
        check("t4_count7", bus.count_o, 7);
        check("t4_ready7", bus.push_ready_o, 0);
        tick;
        drive(2'd0, '0, '0);
        #1;
        check("t4_count_ignored", bus.count_o, 7);
        check("t4_head_intact", bus.issue_bus0_o, e[0]);
        bus.id_allowin_i = 1'b1;
        bus.dual_en_i    = 1'b0;
        #1 check("t4_single_forced", bus.issue_mode_o, 2'b01);
        tick;
        bus.dual_en_i = 1'b1;
        drive(2'd2, e[7], e[8]);
        #1;
        check("t4_ready_again", bus.push_ready_o, 1);
        check("t4_count_after", bus.count_o, 6);
        check("t4_dual_wrap", bus.issue_mode_o, 2'b10);
        check("t4_wrap_bus0", bus.issue_bus0_o, e[1]);
        check("t4_wrap_bus1", bus.issue_bus1_o, e[2]);
        tick;
        drive(2'd0, '0, '0);
        #1;
        check("t4_count_pushissue", bus.count_o, 6);
        check("t4_head_e3", bus.issue_bus0_o, e[3]);

        // Flush with five entries while pushing two
        bus.dual_en_i = 1'b0;
        tick;
        bus.dual_en_i = 1'b1;
        check("t5_count5", bus.count_o, 5);
        bus.flush_i = 1'b1;
        drive(2'd2, alu_a, alu_b);
        #1 check("t5_flush_mode", bus.issue_mode_o, 2'b00);
        tick;
        bus.flush_i = 1'b0;
        drive(2'd0, '0, '0);
        #1;
        check("t5_count0", bus.count_o, 0);
        check("t5_mode", bus.issue_mode_o, 2'b00);
        check("t5_ready", bus.push_ready_o, 1);
`ifdef ISSUE_PERF_EN
        check("perf_dual_2", bus.dual_cnt_o, 2);
        check("perf_stall_4", bus.stall_cnt_o, 4);
`else
        check("perf_dual_off", bus.dual_cnt_o, 0);
        check("perf_stall_off", bus.stall_cnt_o, 0);
`endif

        // Asynchronous reset mid-operation empties the queue without a clock edge
        bus.id_allowin_i = 1'b0;
        drive(2'd2, alu_a, alu_b);
        tick;
        drive(2'd0, '0, '0);
        bus.id_allowin_i = 1'b1;
        #1 check("t6_count2", bus.count_o, 2);
        rst = 1'b0;
        #1;
        check("t6_async_count", bus.count_o, 0);
        check("t6_async_mode", bus.issue_mode_o, 2'b00);
        check("t6_async_dual", bus.dual_cnt_o, 0);
        #1 rst = 1'b1;

        // Ten back-to-back dual-issue cycles
        drive(2'd2, alu_a, alu_b);
        tick;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) drive(2'd2, alu_a, alu_b);
            else       drive(2'd0, '0, '0);
            #1 check("t7_dual_mode", bus.issue_mode_o, 2'b10);
            tick;
        end
        check("t7_count0", bus.count_o, 0);
`ifdef ISSUE_PERF_EN
        check("perf_dual_10", bus.dual_cnt_o, 10);
        check("perf_stall_0", bus.stall_cnt_o, 0);
`else
        check("perf_dual_off2", bus.dual_cnt_o, 0);
        check("perf_stall_off2", bus.stall_cnt_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
